seg_alu: RTL and testbench

SEG_ALU -- requirements
Module: seg_alu

---
 rtl/seg_alu.sv | 187 ++++++++++++++++++
 tb/tb_seg_alu.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/seg_alu.sv
// seg_alu: segmented (bit-serial by SEG bits) ALU with valid/ready handshakes.
// An accepted operation takes exactly NSEG = WIDTH/SEG cycles, one operand
// segment per cycle with a registered carry between segments. The result
// and its flags are loaded into the output registers only on entry to DONE.
//
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   in_valid/in_ready input handshake (in_ready high only in IDLE)
//   A, B, op          operands and opcode (000 AND, 001 OR, 010 ADD,
//                     110 SUB, 111 SLT, 011 SLTU when enabled)
//   out_valid/out_ready output handshake
//   out, overflow, zero, illegal_op  result and flags, held through DONE
//
// Build option: define SEG_ALU_SLTU_EN to make op 011 a legal unsigned
// set-less-than; otherwise op 011 is handled as an illegal opcode.

module seg_alu #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned SEG   = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [2:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             overflow,
   output logic             zero,
   output logic             illegal_op
);

   localparam int unsigned NSEG  = WIDTH / SEG;
   localparam int unsigned IDX_W = (NSEG > 1) ? $clog2(NSEG) : 1;

   localparam logic [2:0] OP_AND  = 3'b000;
   localparam logic [2:0] OP_OR   = 3'b001;
   localparam logic [2:0] OP_ADD  = 3'b010;
   localparam logic [2:0] OP_SUB  = 3'b110;
   localparam logic [2:0] OP_SLT  = 3'b111;
`ifdef SEG_ALU_SLTU_EN
   localparam logic [2:0] OP_SLTU = 3'b011;
`endif

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t state, state_next;

   // Captured operation; a_q/b_q shift right one segment per BUSY cycle.
   logic [WIDTH-1:0] a_q, b_q, acc;
   logic [2:0]       op_q;
   logic             illegal_q;
   logic [IDX_W-1:0] idx;
   logic             carry;

   logic             op_legal, op_sub, last_seg;
   logic [SEG-1:0]   seg_a, seg_b, seg_res;
   logic [SEG:0]     seg_sum;
   logic             seg_ovf;
   logic [WIDTH-1:0] res_full, fin_out;
   logic             fin_ovf;

   // Opcode decode of the incoming op: legality and subtract-type (B inverted, carry-in 1).
   always_comb begin
      op_legal = 1'b0;
      op_sub   = 1'b0;
      case (op)
         OP_AND, OP_OR, OP_ADD: op_legal = 1'b1;
         OP_SUB, OP_SLT: begin
            op_legal = 1'b1;
            op_sub   = 1'b1;
         end
`ifdef SEG_ALU_SLTU_EN
         OP_SLTU: begin
            op_legal = 1'b1;
            op_sub   = 1'b1;
         end
`endif
         default: ;
      endcase
   end

   // Next-state logic.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (in_valid)  state_next = BUSY;
         BUSY:    if (last_seg)  state_next = DONE;
         DONE:    if (out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // One segment of the datapath, plus final result/flag formation.
   always_comb begin
      last_seg = (idx == IDX_W'(NSEG - 1));
      seg_a    = a_q[SEG-1:0];
      seg_b    = b_q[SEG-1:0];
      seg_sum  = {1'b0, seg_a} + {1'b0, seg_b} + {{SEG{1'b0}}, carry};
      // Carry into the segment MSB xor carry out of it; meaningful on the last segment.
      seg_ovf  = (seg_a[SEG-1] ^ seg_b[SEG-1] ^ seg_sum[SEG-1]) ^ seg_sum[SEG];
      case (op_q)
         OP_AND:  seg_res = seg_a & seg_b;
         OP_OR:   seg_res = seg_a | seg_b;
         default: seg_res = seg_sum[SEG-1:0];
      endcase
      // Full result once the current segment lands in the top slot.
      res_full = (acc >> SEG) | (WIDTH'(seg_res) << (WIDTH - SEG));

      fin_out = '0;
      fin_ovf = 1'b0;
      if (!illegal_q) begin
         case (op_q)
            OP_AND, OP_OR: fin_out = res_full;
            OP_ADD, OP_SUB: begin
               fin_out = res_full;
               fin_ovf = seg_ovf;
            end
            // Sign of A-B corrected by overflow gives the true signed compare.
            OP_SLT:  fin_out = WIDTH'(seg_sum[SEG-1] ^ seg_ovf);
`ifdef SEG_ALU_SLTU_EN
            // No carry out of A+~B+1 means A < B unsigned.
            OP_SLTU: fin_out = WIDTH'(~seg_sum[SEG]);
`endif
            default: ;
         endcase
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // Datapath and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         in_ready   <= 1'b1;
         out_valid  <= 1'b0;
         out        <= '0;
         overflow   <= 1'b0;
         zero       <= 1'b0;
         illegal_op <= 1'b0;
         a_q        <= '0;
         b_q        <= '0;
         acc        <= '0;
         op_q       <= '0;
         illegal_q  <= 1'b0;
         idx        <= '0;
         carry      <= 1'b0;
      end else begin
         in_ready  <= (state_next == IDLE);
         out_valid <= (state_next == DONE);
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_q       <= A;
                  b_q       <= op_sub ? ~B : B;
                  op_q      <= op;
                  illegal_q <= !op_legal;
                  idx       <= '0;
                  carry     <= op_sub;
               end
            end
            BUSY: begin
               a_q   <= a_q >> SEG;
               b_q   <= b_q >> SEG;
               acc   <= res_full;
               carry <= seg_sum[SEG];
               idx   <= idx + IDX_W'(1);
               if (last_seg) begin
                  out        <= fin_out;
                  overflow   <= fin_ovf;
                  zero       <= (fin_out == '0);
                  illegal_op <= illegal_q;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_seg_alu.sv
// tb_seg_alu: directed and randomized self-checking bench for seg_alu
// (WIDTH=32, SEG=8). Expected results come from a whole-word arithmetic
// reference model; latency, hold behaviour and reset abort are checked too.

module tb_seg_alu;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] A, B;
   logic [2:0]  op;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out;
   logic        overflow, zero, illegal_op;

   int vectors    = 0;
   int miscompares = 0;

   seg_alu #(.WIDTH(32), .SEG(8)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .A          (A),
      .B          (B),
      .op         (op),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out        (out),
      .overflow   (overflow),
      .zero       (zero),
      .illegal_op (illegal_op)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference model: whole-word arithmetic straight from the operation definitions.
   function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] o,
                                 output logic [31:0] r, output logic v, output logic z,
                                 output logic il);
      r  = 32'h0;
      v  = 1'b0;
      il = 1'b0;
      case (o)
         3'b000: r = a & b;
         3'b001: r = a | b;
         3'b010: begin
            r = a + b;
            v = (a[31] == b[31]) && (r[31] != a[31]);
         end
         3'b110: begin
            r = a - b;
            v = (a[31] != b[31]) && (r[31] != a[31]);
         end
         3'b111: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
`ifdef SEG_ALU_SLTU_EN
         3'b011: r = (a < b) ? 32'd1 : 32'd0;
`endif
         default: il = 1'b1;
      endcase
      z = (r == 32'h0);
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'h0000_0000;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'h7FFF_FFFF;
         4: return 32'h0000_0001;
         default: return $urandom;
      endcase
   endfunction

   // Issue one op, check latency, result, flags, hold for 'hold' cycles, then drain.
   task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] o, input int hold);
      logic [31:0] er;
      logic        ev, ez, eil;
      logic [31:0] first_out;
      int          cyc;
      bit          got;
      model(a, b, o, er, ev, ez, eil);
      @(negedge clk);
      chk({name, " in_ready_before"}, 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      A = a; B = b; op = o;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      A = $urandom; B = $urandom; op = 3'($urandom);
      cyc = 0;
      got = 1'b0;
      while (!got && cyc < 16) begin
         @(posedge clk);
         cyc++;
         #1;
         if (out_valid) got = 1'b1;
      end
      chk({name, " latency"}, 32'(cyc), 32'd4);
      if (!got) return;
      chk({name, " out"}, out, er);
      chk({name, " overflow"}, 32'(overflow), 32'(ev));
      chk({name, " zero"}, 32'(zero), 32'(ez));
      chk({name, " illegal_op"}, 32'(illegal_op), 32'(eil));
      chk({name, " in_ready_done"}, 32'(in_ready), 32'd0);
      first_out = out;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         chk({name, " hold_out"}, out, first_out);
         chk({name, " hold_valid"}, 32'(out_valid), 32'd1);
         chk({name, " hold_in_ready"}, 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk({name, " drain_valid"}, 32'(out_valid), 32'd0);
      chk({name, " drain_in_ready"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      A = '0; B = '0; op = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst in_ready", 32'(in_ready), 32'd1);
      chk("rst out_valid", 32'(out_valid), 32'd0);
      chk("rst out", out, 32'h0);
      chk("rst overflow", 32'(overflow), 32'd0);
      chk("rst zero", 32'(zero), 32'd0);
      chk("rst illegal_op", 32'(illegal_op), 32'd0);
      reset = 1'b0;

      // Directed boundary cases.
      run_op("add_wrap", 32'h0000_0001, 32'hFFFF_FFFF, 3'b010, 0);
      run_op("slt_neg", 32'hFFFF_FFFF, 32'h0000_0001, 3'b111, 0);
      run_op("slt_ovf", 32'h8000_0000, 32'h0000_0001, 3'b111, 0);
      run_op("sub_ovf", 32'h8000_0000, 32'h0000_0001, 3'b110, 1);
      run_op("add_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 3'b010, 0);
      run_op("or_hold", 32'hFFFF_0000, 32'h0000_FFFF, 3'b001, 3);

      // Reset during the second BUSY cycle aborts the op.
      @(negedge clk);
      in_valid = 1'b1;
      A = 32'h1234_5678; B = 32'h1111_1111; op = 3'b010;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      chk("abort in_ready", 32'(in_ready), 32'd1);
      chk("abort out_valid", 32'(out_valid), 32'd0);
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1;
         chk("abort no_valid", 32'(out_valid), 32'd0);
      end
      run_op("and_after_rst", 32'hC000_0001, 32'hCE5F_F9F3, 3'b000, 0);

      // Optional / illegal opcodes.
      run_op("op011", 32'h0000_0001, 32'hFFFF_FFFF, 3'b011, 0);
      run_op("op100", 32'h0000_0001, 32'hFFFF_FFFF, 3'b100, 0);
      run_op("op101", 32'hDEAD_BEEF, 32'h0000_0000, 3'b101, 1);

      // Randomized operations against the reference model.
      for (int n = 0; n < 40; n++) begin
         run_op("rand", pick(), pick(), 3'($urandom), $urandom_range(0, 3));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
